lfsr_msg_decrypter: RTL and testbench



---
 rtl/lfsr_dec_pkg.sv | 19 +
 rtl/lfsr5_step.sv | 11 +
 rtl/lfsr_msg_decrypter.sv | 162 ++++++++++++++++
 tb/tb_lfsr_msg_decrypter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_dec_pkg.sv
// Shared constants and types for the LFSR message decrypter: frame size,
// candidate tap patterns and the controller state encoding.
package lfsr_dec_pkg;

    localparam int MSG_LEN    = 64;
    localparam int NUM_PTRN   = 6;
    localparam int SRCH_STEPS = 6;

    localparam logic [4:0] TAP_PTRN [NUM_PTRN] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SEARCH,
        DECRYPT,
        DONE
    } state_t;

endpackage

// File: rtl/lfsr5_step.sv
// One step of the 5-bit keystream generator: shift left, feed back the
// parity of the tapped bits into bit 0.
module lfsr5_step (
    input  logic [4:0] i_state,
    input  logic [4:0] i_tap,
    output logic [4:0] o_next
);

    assign o_next = {i_state[3:0], ^(i_state & i_tap)};

endmodule

// File: rtl/lfsr_msg_decrypter.sv
// Recovers the LFSR seed and tap pattern from a known preamble, then decrypts
// the 64-byte frame one byte per cycle, stripping the preamble.
module lfsr_msg_decrypter
    import lfsr_dec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [7:0] preamble,
    input  logic [7:0] pre_len,
    input  logic [7:0] encrypted_data [MSG_LEN],
    output logic [7:0] decrypted_data [MSG_LEN],
    output logic       done
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_clear;

    logic [4:0] r_seed;
    logic [2:0] r_p;
    logic [4:0] r_tap;
    logic [4:0] r_lfsr;
    logic [5:0] r_idx;
    logic       r_done;
    logic [7:0] r_dec [MSG_LEN];

    logic [4:0] w_target [SRCH_STEPS+1];
    logic [4:0] w_stage_next [SRCH_STEPS+1];
    logic [SRCH_STEPS-1:0] w_stage_ok;
    logic [4:0] w_srch_tap;
    logic       w_match;
    logic [4:0] w_lfsr_next;
    logic       w_in_msg;
    logic [5:0] w_wr_addr;
    logic       w_unused;

    assign w_unused   = ^preamble[7:5];
    assign w_srch_tap = TAP_PTRN[r_p];

    // Expected keystream values implied by the preamble.
    for (genvar g = 0; g <= SRCH_STEPS; g++) begin : g_target
        assign w_target[g] = encrypted_data[g][4:0] ^ preamble[4:0];
    end

    // Once every earlier step matched, L[g-1] equals its target, so each
    // stage can step from the target instead of chaining six steps in series.
    assign w_stage_next[0] = '0;
    for (genvar g = 1; g <= SRCH_STEPS; g++) begin : g_search
        lfsr5_step u_srch_step (
            .i_state (g == 1 ? r_seed : w_target[g-1]),
            .i_tap   (w_srch_tap),
            .o_next  (w_stage_next[g])
        );
        assign w_stage_ok[g-1] = (w_stage_next[g] == w_target[g]);
    end

    assign w_match = &w_stage_ok;

    lfsr5_step u_dec_step (
        .i_state (r_lfsr),
        .i_tap   (r_tap),
        .o_next  (w_lfsr_next)
    );

    assign w_in_msg  = ({2'b00, r_idx} >= pre_len);
    assign w_wr_addr = r_idx - pre_len[5:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        if (init) begin
            w_next_state = IDLE;
            w_clear      = 1'b1;
        end else begin
            unique case (r_state)
                IDLE:    begin
                    w_next_state = SEED;
                    w_clear      = 1'b1;
                end
                SEED:    w_next_state = SEARCH;
                SEARCH:  begin
                    if (w_match) begin
                        w_next_state = DECRYPT;
                    end else if (r_p == 3'(NUM_PTRN-1)) begin
                        w_next_state = DONE;
                    end
                end
                DECRYPT: begin
                    if (r_idx == 6'(MSG_LEN-1)) begin
                        w_next_state = DONE;
                    end
                end
                DONE:    w_next_state = DONE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // NOTE: the output bytes are a register bank, not a RAM, so they take
    // the synchronous reset like any other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed <= '0;
            r_p    <= '0;
            r_tap  <= '0;
            r_lfsr <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_dec[i] <= 8'h00;
            end
        end else begin
            r_done <= (w_next_state == DONE);
            if (w_clear) begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    r_dec[i] <= 8'h00;
                end
            end else begin
                unique case (r_state)
                    SEED: begin
                        r_seed <= w_target[0];
                        r_p    <= '0;
                    end
                    SEARCH: begin
                        if (w_match) begin
                            r_tap  <= w_srch_tap;
                            r_lfsr <= r_seed;
                            r_idx  <= '0;
                        end else begin
                            r_p <= r_p + 3'd1;
                        end
                    end
                    DECRYPT: begin
                        r_lfsr <= w_lfsr_next;
                        r_idx  <= r_idx + 6'd1;
                        if (w_in_msg) begin
                            r_dec[w_wr_addr] <= encrypted_data[r_idx] ^ {3'b000, r_lfsr};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign decrypted_data = r_dec;
    assign done           = r_done;

endmodule

// File: tb/tb_lfsr_msg_decrypter.sv
// Randomized self-checking bench: encrypts frames with a chosen seed/tap and
// compares the DUT against a keystream search model built from the rules.
module tb_lfsr_msg_decrypter;

    localparam int N = 64;
    localparam logic [4:0] TAPS [6] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [7:0] pre;
    logic [7:0] plen;
    logic [7:0] enc [N];
    logic [7:0] dec [N];
    logic       done;

    logic [7:0] plain [N];
    logic [7:0] exp_dec [N];
    int         exp_lat;
    int         n_checks = 0;
    int         n_err    = 0;

    lfsr_msg_decrypter dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .preamble       (pre),
        .pre_len        (plen),
        .encrypted_data (enc),
        .decrypted_data (dec),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ks_next(input logic [4:0] l, input logic [4:0] tap);
        int v;
        v = (int'(l) * 2 + ($countones(l & tap) % 2)) % 32;
        return 5'(v);
    endfunction

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < N; i++) if (dec[i] != 8'h00) c++;
        return c;
    endfunction

    // Plaintext: pre_len preamble bytes followed by random body bytes.
    task automatic make_plain();
        for (int i = 0; i < N; i++)
            plain[i] = (i < int'(plen)) ? pre : 8'($urandom_range(255));
    endtask

    task automatic encrypt(input logic [4:0] seed, input logic [4:0] tap);
        logic [4:0] l = seed;
        for (int i = 0; i < N; i++) begin
            enc[i] = plain[i] ^ {3'b000, l};
            l = ks_next(l, tap);
        end
    endtask

    // Reference: try each tap on the preamble keystream, then decrypt.
    task automatic model();
        logic [4:0] seed, l;
        int found = -1;
        seed = enc[0][4:0] ^ pre[4:0];
        for (int p = 0; p < 6 && found < 0; p++) begin
            bit ok = 1;
            l = seed;
            for (int i = 1; i <= 6; i++) begin
                l = ks_next(l, TAPS[p]);
                if (l != (enc[i][4:0] ^ pre[4:0])) ok = 0;
            end
            if (ok) found = p;
        end
        for (int i = 0; i < N; i++) exp_dec[i] = 8'h00;
        if (found >= 0) begin
            l = seed;
            for (int i = 0; i < N; i++) begin
                if (i >= int'(plen)) exp_dec[i - int'(plen)] = enc[i] ^ {3'b000, l};
                l = ks_next(l, TAPS[found]);
            end
            exp_lat = found + 67;
        end else begin
            exp_lat = 8;
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int  cycles = 0;
        bit  got = 0;
        while (cycles < 100 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) got = 1;
        end
        check({name, " latency"}, 32'(cycles), 32'(exp_lat));
        for (int i = 0; i < N; i++)
            check($sformatf("%s byte%0d", name, i), {24'h0, dec[i]}, {24'h0, exp_dec[i]});
    endtask

    task automatic full_case(input string name, input logic [4:0] seed, input logic [4:0] tap);
        make_plain();
        encrypt(seed, tap);
        model();
        start_run();
        finish_run(name);
    endtask

    initial begin
        string msg;
        reset = 1'b1;
        init  = 1'b1;
        pre   = 8'h7E;
        plen  = 8'd9;
        for (int i = 0; i < N; i++) enc[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset done", {31'h0, done}, 32'h0);
        check("reset zeros", 32'(count_nonzero()), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal frame with known message.
        msg  = "Hey_Hamm_Look_Im_Picasso";
        pre  = 8'h7E;
        plen = 8'd9;
        for (int i = 0; i < N; i++) plain[i] = 8'h7E;
        for (int k = 0; k < msg.len(); k++) plain[9 + k] = msg[k];
        encrypt(5'h01, 5'h1B);
        model();
        start_run();
        finish_run("nominal");
        check("nominal lat<=72", 32'(exp_lat <= 72), 32'h1);
        for (int k = 0; k < 24; k++)
            check($sformatf("msg char%0d", k), {24'h0, dec[k]}, {24'h0, msg[k]});
        for (int k = 24; k < 55; k++)
            check($sformatf("msg pad%0d", k), {24'h0, dec[k]}, 32'h7E);
        for (int k = 55; k < 64; k++)
            check($sformatf("msg tail%0d", k), {24'h0, dec[k]}, 32'h0);

        // Every candidate tap.
        plen = 8'd7;
        for (int t = 0; t < 6; t++) full_case($sformatf("tap%0d", t), 5'h1F, TAPS[t]);

        // Longest preamble.
        plen = 8'd12;
        full_case("plen12", 5'h10, TAPS[$urandom_range(5)]);
        check("plen12 first", {24'h0, dec[0]}, {24'h0, plain[12]});

        // Corrupted preamble: no tap should match.
        plen = 8'd9;
        make_plain();
        encrypt(5'h01, 5'h1B);
        enc[3] = enc[3] ^ 8'h01;
        model();
        start_run();
        finish_run("corrupt");
        check("corrupt done", {31'h0, done}, 32'h1);
        check("corrupt zeros", 32'(count_nonzero()), 32'h0);

        // Random frames.
        for (int r = 0; r < 5; r++) begin
            plen = 8'($urandom_range(12, 7));
            pre  = 8'($urandom_range(255));
            full_case($sformatf("rand%0d", r), 5'($urandom_range(31)), TAPS[$urandom_range(5)]);
        end

        // Abort during DECRYPT, then restart.
        pre  = 8'h7E;
        plen = 8'd10;
        make_plain();
        encrypt(5'h0B, 5'h17);
        model();
        start_run();
        repeat (20) @(posedge clk);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", {31'h0, done}, 32'h0);
        check("abort zeros", 32'(count_nonzero()), 32'h0);
        repeat (2) @(negedge clk);
        init = 1'b0;
        finish_run("restart");

        // Reset while DONE.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst done", {31'h0, done}, 32'h0);
        check("rst zeros", 32'(count_nonzero()), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
